// File: rtl/dm_responder.sv
// Data-memory responder: one word/byte load or store at a time, WAIT_CYCLES wait states, single-cycle ack.
// Optional macro DM_ALIGN_CHECK_EN rejects misaligned word accesses (ack+err, no write, rdata=0).
module dm_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic        bmode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic                bmode_q, bmode_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;

  logic [31:0]         mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0]   word_idx;
  logic [31:0]         cur_word;
  logic [31:0]         byte_word;
  logic [7:0]          sel_byte;
  logic                reject;
  logic                mem_we;
  logic [31:0]         mem_wdata;
  logic                unused_addr_bits;

  // Address bits above the storage range are ignored, so addresses wrap.
  assign unused_addr_bits = ^addr[31:ADDR_W+2];

  assign word_idx = addr_q[ADDR_W+1:2];
  assign cur_word = mem[word_idx];

  always_comb begin
    sel_byte  = cur_word[7:0];
    byte_word = cur_word;
    case (addr_q[1:0])
      2'd0: begin sel_byte = cur_word[7:0];   byte_word[7:0]   = wdata_q[7:0]; end
      2'd1: begin sel_byte = cur_word[15:8];  byte_word[15:8]  = wdata_q[7:0]; end
      2'd2: begin sel_byte = cur_word[23:16]; byte_word[23:16] = wdata_q[7:0]; end
      default: begin sel_byte = cur_word[31:24]; byte_word[31:24] = wdata_q[7:0]; end
    endcase
  end

`ifdef DM_ALIGN_CHECK_EN
  assign reject = !bmode_q && (addr_q[1:0] != 2'd0);
`else
  assign reject = 1'b0;
`endif

  // Writes happen only in ACCESS, so a reset earlier in the request leaves storage untouched.
  assign mem_we    = (state_q == S_ACCESS) && we_q && !reject;
  assign mem_wdata = bmode_q ? byte_word : wdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    bmode_d = bmode_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          bmode_d = bmode;
          addr_d  = addr[ADDR_W+1:0];
          wdata_d = wdata;
          busy_d  = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ACCESS: begin
        state_d = S_RESP;
        ack_d   = 1'b1;
        err_d   = reject;
        if (reject)      rdata_d = 32'd0;
        else if (!we_q)  rdata_d = bmode_q ? {{24{sel_byte[7]}}, sel_byte} : cur_word;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      bmode_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      bmode_q <= bmode_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[word_idx] <= mem_wdata;
  end

  assign rdata     = rdata_q;
  assign ack       = ack_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: instance a uses WAIT_CYCLES=2, instance b uses WAIT_CYCLES=0.
module tb_dm_responder;

  localparam int WC_A = 2;
  localparam int WC_B = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  logic        req_a = 1'b0, req_b = 1'b0;
  logic        we = 1'b0, bmode = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [31:0] rdata_a, rdata_b;
  logic        ack_a, ack_b, err_a, err_b, busy_a, busy_b;
  logic [1:0]  st_a, st_b;

  dm_responder #(.ADDR_W(10), .WAIT_CYCLES(WC_A)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .we(we), .bmode(bmode), .addr(addr), .wdata(wdata),
    .rdata(rdata_a), .ack(ack_a), .err(err_a), .busy(busy_a), .dbg_state(st_a));

  dm_responder #(.ADDR_W(10), .WAIT_CYCLES(WC_B)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .we(we), .bmode(bmode), .addr(addr), .wdata(wdata),
    .rdata(rdata_b), .ack(ack_b), .err(err_b), .busy(busy_b), .dbg_state(st_b));

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rd_a[$], exp_rd_b[$];
  logic        exp_err_a[$], exp_err_b[$];
  int          exp_cyc_a[$], exp_cyc_b[$];
  logic [31:0] last_rd_a = 32'd0, last_rd_b = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic prev_ack_a = 1'b0, prev_ack_b = 1'b0;
  int   run_a = 0, run_b = 0;

  task automatic mon(input int b, input logic ack_i, input logic err_i, input logic [31:0] rd_i,
                     input logic busy_i, input logic prev_ack, inout int run);
    logic [31:0] e_rd;
    logic        e_err;
    int          e_cyc;
    int          wc;
    bit          empty;
    wc = (b == 0) ? WC_A : WC_B;
    if (ack_i) begin
      chk(b == 0 ? "a_ack_width" : "b_ack_width", {31'd0, prev_ack}, 32'd0);
      empty = (b == 0) ? (exp_rd_a.size() == 0) : (exp_rd_b.size() == 0);
      if (empty) begin
        chk(b == 0 ? "a_unexpected_ack" : "b_unexpected_ack", 32'd1, 32'd0);
      end else begin
        if (b == 0) begin
          e_rd = exp_rd_a.pop_front(); e_err = exp_err_a.pop_front(); e_cyc = exp_cyc_a.pop_front();
        end else begin
          e_rd = exp_rd_b.pop_front(); e_err = exp_err_b.pop_front(); e_cyc = exp_cyc_b.pop_front();
        end
        chk(b == 0 ? "a_rdata" : "b_rdata", rd_i, e_rd);
        chk(b == 0 ? "a_err" : "b_err", {31'd0, err_i}, {31'd0, e_err});
        chk(b == 0 ? "a_ack_latency" : "b_ack_latency", 32'(cyc), 32'(e_cyc));
      end
    end else if (err_i) begin
      chk(b == 0 ? "a_err_without_ack" : "b_err_without_ack", 32'd1, 32'd0);
    end
    if (rst) run = 0;
    else if (busy_i) run++;
    else if (run != 0) begin
      chk(b == 0 ? "a_busy_len" : "b_busy_len", 32'(run), 32'(wc + 2));
      run = 0;
    end
  endtask

  always @(negedge clk) begin
    mon(0, ack_a, err_a, rdata_a, busy_a, prev_ack_a, run_a);
    mon(1, ack_b, err_b, rdata_b, busy_b, prev_ack_b, run_b);
    prev_ack_a = ack_a;
    prev_ack_b = ack_b;
  end

  // ---------------- driver ----------------
  task automatic push_exp(input int b, input logic w, input logic [31:0] exp_load,
                          input logic e_err, input int ack_cyc);
    logic [31:0] e;
    if (b == 0) begin
      e = e_err ? 32'd0 : (w ? last_rd_a : exp_load);
      last_rd_a = e;
      exp_rd_a.push_back(e); exp_err_a.push_back(e_err); exp_cyc_a.push_back(ack_cyc);
    end else begin
      e = e_err ? 32'd0 : (w ? last_rd_b : exp_load);
      last_rd_b = e;
      exp_rd_b.push_back(e); exp_err_b.push_back(e_err); exp_cyc_b.push_back(ack_cyc);
    end
  endtask

  task automatic wait_ack(input int b, input string name);
    int n = 0;
    while (!(b == 0 ? ack_a : ack_b) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk(name, 32'd0, 32'd1);
  endtask

  task automatic txn(input int b, input logic w, input logic bm, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] exp_load, input logic e_err);
    int wc;
    wc = (b == 0) ? WC_A : WC_B;
    @(negedge clk);
    we = w; bmode = bm; addr = a; wdata = wd;
    if (b == 0) req_a = 1'b1; else req_b = 1'b1;
    push_exp(b, w, exp_load, e_err, cyc + 1 + wc + 1);
    @(negedge clk);
    req_a = 1'b0; req_b = 1'b0;
    wait_ack(b, "txn_timeout");
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_ack"},  {31'd0, ack_a},  32'd0);
    chk({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
    chk({tag, "_err"},  {31'd0, err_a},  32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    int nack;
    int n;

    repeat (3) @(negedge clk);
    idle_chk("reset");
    chk("reset_rdata_a", rdata_a, 32'd0);
    chk("reset_state_a", {30'd0, st_a}, 32'd0);
    chk("reset_rdata_b", rdata_b, 32'd0);
    chk("reset_busy_b", {31'd0, busy_b}, 32'd0);
    rst = 1'b0;

    // word store/load with latency and busy window
    txn(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
    txn(0, 1'b0, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);

    // byte lanes
    txn(0, 1'b1, 1'b0, 32'h20, 32'h11223344, 32'd0, 1'b0);
    txn(0, 1'b1, 1'b1, 32'h22, 32'h000000AA, 32'd0, 1'b0);
    txn(0, 1'b0, 1'b0, 32'h20, 32'd0, 32'h11AA3344, 1'b0);
    txn(0, 1'b0, 1'b1, 32'h22, 32'd0, 32'hFFFFFFAA, 1'b0);
    txn(0, 1'b0, 1'b1, 32'h23, 32'd0, 32'h00000011, 1'b0);
    txn(0, 1'b0, 1'b1, 32'h20, 32'd0, 32'h00000044, 1'b0);
    txn(0, 1'b1, 1'b1, 32'h21, 32'h12345680, 32'd0, 1'b0);
    txn(0, 1'b0, 1'b0, 32'h20, 32'd0, 32'h11AA8044, 1'b0);
    txn(0, 1'b0, 1'b1, 32'h21, 32'd0, 32'hFFFFFF80, 1'b0);

    // req held high for three back-to-back loads
    @(negedge clk);
    we = 1'b0; bmode = 1'b0; addr = 32'h10; wdata = 32'd0; req_a = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 3; k++) push_exp(0, 1'b0, 32'hDEADBEEF, 1'b0, c0 + 1 + k * (WC_A + 3) + WC_A + 1);
    nack = 0; n = 0;
    while (nack < 3 && n < 60) begin
      @(negedge clk);
      n++;
      if (ack_a) nack++;
    end
    req_a = 1'b0;
    chk("held_req_acks", 32'(nack), 32'd3);
    @(negedge clk);

    // req toggling during WAIT is ignored
    txn(0, 1'b1, 1'b0, 32'h54, 32'h0BADF00D, 32'd0, 1'b0);
    @(negedge clk);
    we = 1'b1; bmode = 1'b0; addr = 32'h50; wdata = 32'h00000055; req_a = 1'b1;
    push_exp(0, 1'b1, 32'd0, 1'b0, cyc + 1 + WC_A + 1);
    @(negedge clk);
    addr = 32'h54; wdata = 32'h99999999;
    @(negedge clk);
    req_a = 1'b0;
    @(negedge clk);
    req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    wait_ack(0, "toggle_timeout");
    txn(0, 1'b0, 1'b0, 32'h50, 32'd0, 32'h00000055, 1'b0);
    txn(0, 1'b0, 1'b0, 32'h54, 32'd0, 32'h0BADF00D, 1'b0);

    // reset during WAIT discards the pending store
    txn(0, 1'b1, 1'b0, 32'h30, 32'h12345678, 32'd0, 1'b0);
    @(negedge clk);
    we = 1'b1; bmode = 1'b0; addr = 32'h30; wdata = 32'hFFFFFFFF; req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    rst = 1'b1;
    #1;
    idle_chk("in_reset0");
    repeat (2) @(negedge clk);
    idle_chk("in_reset1");
    chk("in_reset_rdata", rdata_a, 32'd0);
    rst = 1'b0;
    last_rd_a = 32'd0;
    repeat (4) @(negedge clk);
    idle_chk("post_reset");
    txn(0, 1'b0, 1'b0, 32'h30, 32'd0, 32'h12345678, 1'b0);

    // misaligned word store
    txn(0, 1'b1, 1'b0, 32'h40, 32'h01020304, 32'd0, 1'b0);
`ifdef DM_ALIGN_CHECK_EN
    txn(0, 1'b1, 1'b0, 32'h41, 32'hAAAAAAAA, 32'd0, 1'b1);
    txn(0, 1'b0, 1'b0, 32'h40, 32'd0, 32'h01020304, 1'b0);
    txn(0, 1'b0, 1'b0, 32'h43, 32'd0, 32'd0, 1'b1);
    txn(0, 1'b0, 1'b1, 32'h41, 32'd0, 32'h00000003, 1'b0);
`else
    txn(0, 1'b1, 1'b0, 32'h41, 32'hAAAAAAAA, 32'd0, 1'b0);
    txn(0, 1'b0, 1'b0, 32'h40, 32'd0, 32'hAAAAAAAA, 1'b0);
    txn(0, 1'b0, 1'b0, 32'h43, 32'd0, 32'hAAAAAAAA, 1'b0);
`endif

    // zero wait states and address wrap
    txn(1, 1'b1, 1'b0, 32'h00001004, 32'hCAFEF00D, 32'd0, 1'b0);
    txn(1, 1'b0, 1'b0, 32'h00000004, 32'd0, 32'hCAFEF00D, 1'b0);
    txn(1, 1'b1, 1'b1, 32'hFFFFF007, 32'h000000F0, 32'd0, 1'b0);
    txn(1, 1'b0, 1'b0, 32'h00000004, 32'd0, 32'hF0FEF00D, 1'b0);
    txn(1, 1'b0, 1'b1, 32'h00000007, 32'd0, 32'hFFFFFFF0, 1'b0);

    repeat (4) @(negedge clk);
    chk("a_queue_drained", 32'(exp_rd_a.size()), 32'd0);
    chk("b_queue_drained", 32'(exp_rd_b.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // hard stop if something wedges
  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d expected=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
